// File: rtl/bcd_updown_7seg.sv
// N-digit BCD up/down counter with programmable wrap and validated load, driving
// a time-multiplexed 7-segment display with leading-zero blanking.
module bcd_digit_step (
    input  logic [3:0] d,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] q
);
    always_comb begin
        q = d;
        if (cin) begin
            if (up) q = (d == 4'd9) ? 4'd0 : d + 4'd1;
            else    q = (d == 4'd0) ? 4'd9 : d - 4'd1;
        end
    end
endmodule

module bcd_updown_7seg #(
    parameter int DIGITS     = 4,
    parameter int TICK_WAIT  = 50000000,
    parameter int SCAN_WAIT  = 50000,
    parameter int MAX_VALUE  = 9999,
    parameter int BLANK_LZ   = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_up,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_load_val,
    output logic [4*DIGITS-1:0]   o_value,
    output logic                  o_wrap,
    output logic [7:0]            o_seg,
    output logic [DIGITS-1:0]     o_dig
);
    localparam int W  = 4*DIGITS;
    localparam int PW = (TICK_WAIT > 1) ? $clog2(TICK_WAIT) : 1;
    localparam int SW = (SCAN_WAIT > 1) ? $clog2(SCAN_WAIT) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h3F;
            4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;
            4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;
            4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;
            4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;
            4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    logic [W-1:0]      cnt, step_val;
    logic [PW-1:0]     pre;
    logic [SW-1:0]     scan_cnt;
    logic [IW-1:0]     scan_idx;
    logic [DIGITS-1:0] cy, zf, nib_ok;
    logic              tick, load_ok;

    // cy[g]: digit g steps (carry on up, borrow on down); zf[g]: digits g..top all zero
    assign cy[0] = 1'b1;
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bcd_digit_step u_step (
                .d  (cnt[4*g +: 4]),
                .up (i_up),
                .cin(cy[g]),
                .q  (step_val[4*g +: 4])
            );
            assign nib_ok[g] = (i_load_val[4*g +: 4] <= 4'd9);
            if (g > 0) begin : g_cy
                assign cy[g] = cy[g-1] & (i_up ? (cnt[4*(g-1) +: 4] == 4'd9)
                                               : (cnt[4*(g-1) +: 4] == 4'd0));
            end
            if (g == DIGITS-1) begin : g_zt
                assign zf[g] = (cnt[4*g +: 4] == 4'd0);
            end else begin : g_zn
                assign zf[g] = zf[g+1] & (cnt[4*g +: 4] == 4'd0);
            end
        end
    endgenerate

    assign tick    = i_en && (pre == PW'(TICK_WAIT-1));
    assign load_ok = i_load && (&nib_ok) && (i_load_val <= MAX_BCD);
    assign o_value = cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= '0;
            pre    <= '0;
            o_wrap <= 1'b0;
        end else begin
            o_wrap <= 1'b0;
            if (load_ok) begin
                cnt <= i_load_val;
                pre <= '0;
            end else if (i_en) begin
                pre <= tick ? '0 : pre + 1'b1;
                if (tick) begin
                    if (i_up) begin
                        if (cnt == MAX_BCD) begin
                            cnt    <= '0;
                            o_wrap <= 1'b1;
                        end else cnt <= step_val;
                    end else begin
                        if (cnt == '0) begin
                            cnt    <= MAX_BCD;
                            o_wrap <= 1'b1;
                        end else cnt <= step_val;
                    end
                end
            end
        end
    end

    logic [3:0]        cur_d;
    logic              blank, dp;
    logic [7:0]        seg_raw;
    logic [DIGITS-1:0] dig_raw;

    assign cur_d   = cnt[4*scan_idx +: 4];
    assign blank   = (BLANK_LZ != 0) && (scan_idx != '0) && zf[scan_idx];
    assign dp      = (scan_idx == '0) && !i_up;
    assign seg_raw = blank ? 8'h00 : {dp, seg7(cur_d)};
    assign dig_raw = DIGITS'(1) << scan_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            o_seg    <= {8{POL}};
            o_dig    <= {DIGITS{POL}};
        end else begin
            if (scan_cnt == SW'(SCAN_WAIT-1)) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IW'(DIGITS-1)) ? '0 : scan_idx + 1'b1;
            end else scan_cnt <= scan_cnt + 1'b1;
            o_seg <= seg_raw ^ {8{POL}};
            o_dig <= dig_raw ^ {DIGITS{POL}};
        end
    end
endmodule

// File: tb/tb_bcd_updown_7seg.sv
// Directed bench: four instances (2-digit wrap 99, 2-digit wrap 59, 4-digit with and
// without leading-zero blanking) share one stimulus bus; each task watches one or more.
module tb_bcd_updown_7seg;
    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [15:0] lv;
    logic [7:0]  va, vb, sa, sb, sc, sd;
    logic [15:0] vc, vd;
    logic        wa, wb, wc, wd;
    logic [1:0]  da, db;
    logic [3:0]  dc, dd;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_updown_7seg #(.DIGITS(2), .TICK_WAIT(4), .SCAN_WAIT(2), .MAX_VALUE(99), .BLANK_LZ(1), .ACTIVE_LOW(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load), .i_load_val(lv[7:0]),
        .o_value(va), .o_wrap(wa), .o_seg(sa), .o_dig(da));
    bcd_updown_7seg #(.DIGITS(2), .TICK_WAIT(4), .SCAN_WAIT(2), .MAX_VALUE(59), .BLANK_LZ(1), .ACTIVE_LOW(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load), .i_load_val(lv[7:0]),
        .o_value(vb), .o_wrap(wb), .o_seg(sb), .o_dig(db));
    bcd_updown_7seg #(.DIGITS(4), .TICK_WAIT(4), .SCAN_WAIT(2), .MAX_VALUE(9999), .BLANK_LZ(1), .ACTIVE_LOW(1)) u_c (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load), .i_load_val(lv),
        .o_value(vc), .o_wrap(wc), .o_seg(sc), .o_dig(dc));
    bcd_updown_7seg #(.DIGITS(4), .TICK_WAIT(4), .SCAN_WAIT(2), .MAX_VALUE(9999), .BLANK_LZ(0), .ACTIVE_LOW(1)) u_d (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load), .i_load_val(lv),
        .o_value(vd), .o_wrap(wd), .o_seg(sd), .o_dig(dd));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = '0;
        step(1);
        rst = 1'b0;
    endtask

    task automatic load_pulse(input logic [15:0] val);
        lv = val; load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic test_reset();
        do_reset();
        n_cmp++; if (va !== 8'h00) begin n_bad++; $display("FAIL rst_value got %h want 00", va); end
        n_cmp++; if (wa !== 1'b0) begin n_bad++; $display("FAIL rst_wrap got %b want 0", wa); end
        n_cmp++; if (sa !== 8'hFF) begin n_bad++; $display("FAIL rst_seg got %h want FF", sa); end
        n_cmp++; if (da !== 2'b11) begin n_bad++; $display("FAIL rst_dig got %b want 11", da); end
        n_cmp++; if (dc !== 4'hF) begin n_bad++; $display("FAIL rst_dig4 got %h want F", dc); end
        n_cmp++; if (vc !== 16'h0000) begin n_bad++; $display("FAIL rst_value4 got %h want 0000", vc); end
    endtask

    task automatic test_count_up();
        do_reset(); en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(4);
            n_cmp++; if (va !== bcd2(k)) begin n_bad++; $display("FAIL up_step%0d got %h want %h", k, va, bcd2(k)); end
        end
        load_pulse(16'h0098);
        n_cmp++; if (va !== 8'h98) begin n_bad++; $display("FAIL up_load98 got %h want 98", va); end
        step(4);
        n_cmp++; if (va !== 8'h99) begin n_bad++; $display("FAIL up_99 got %h want 99", va); end
        step(3);
        n_cmp++; if (wa !== 1'b0) begin n_bad++; $display("FAIL up_prewrap got %b want 0", wa); end
        step(1);
        n_cmp++; if (va !== 8'h00) begin n_bad++; $display("FAIL up_wrapval got %h want 00", va); end
        n_cmp++; if (wa !== 1'b1) begin n_bad++; $display("FAIL up_wrap got %b want 1", wa); end
        step(1);
        n_cmp++; if (wa !== 1'b0) begin n_bad++; $display("FAIL up_wrapend got %b want 0", wa); end
    endtask

    task automatic test_count_down();
        do_reset(); en = 1'b1; up = 1'b0;
        load_pulse(16'h0001);
        n_cmp++; if (vb !== 8'h01) begin n_bad++; $display("FAIL dn_load got %h want 01", vb); end
        step(4);
        n_cmp++; if (vb !== 8'h00) begin n_bad++; $display("FAIL dn_00 got %h want 00", vb); end
        n_cmp++; if (wb !== 1'b0) begin n_bad++; $display("FAIL dn_nowrap got %b want 0", wb); end
        step(4);
        n_cmp++; if (vb !== 8'h59) begin n_bad++; $display("FAIL dn_59 got %h want 59", vb); end
        n_cmp++; if (wb !== 1'b1) begin n_bad++; $display("FAIL dn_wrap got %b want 1", wb); end
        step(1);
        n_cmp++; if (wb !== 1'b0) begin n_bad++; $display("FAIL dn_wrapend got %b want 0", wb); end
        for (int k = 0; k < 8; k++) begin
            step(1);
            n_cmp++;
            if (sb[7] !== ((db == 2'b10) ? 1'b0 : 1'b1)) begin
                n_bad++; $display("FAIL dn_dp dig=%b got dp=%b want %b", db, sb[7], (db == 2'b10) ? 1'b0 : 1'b1);
            end
        end
    endtask

    task automatic test_load();
        do_reset(); en = 1'b1; up = 1'b1;
        step(3);
        load_pulse(16'h0042);
        n_cmp++; if (va !== 8'h42) begin n_bad++; $display("FAIL ld_42 got %h want 42", va); end
        n_cmp++; if (vb !== 8'h42) begin n_bad++; $display("FAIL ld_42b got %h want 42", vb); end
        step(3);
        n_cmp++; if (va !== 8'h42) begin n_bad++; $display("FAIL ld_hold got %h want 42", va); end
        step(1);
        n_cmp++; if (va !== 8'h43) begin n_bad++; $display("FAIL ld_43 got %h want 43", va); end
        load_pulse(16'h004A);
        n_cmp++; if (va !== 8'h43) begin n_bad++; $display("FAIL ld_4A got %h want 43", va); end
        step(2);
        n_cmp++; if (va !== 8'h43) begin n_bad++; $display("FAIL ld_4Ahold got %h want 43", va); end
        step(1);
        n_cmp++; if (va !== 8'h44) begin n_bad++; $display("FAIL ld_44 got %h want 44", va); end
        load_pulse(16'h0075);
        n_cmp++; if (va !== 8'h75) begin n_bad++; $display("FAIL ld_75a got %h want 75", va); end
        n_cmp++; if (vb !== 8'h44) begin n_bad++; $display("FAIL ld_75b got %h want 44", vb); end
    endtask

    task automatic test_enable();
        logic [1:0] prev;
        int trans;
        do_reset(); en = 1'b1; up = 1'b1;
        step(4);
        n_cmp++; if (va !== 8'h01) begin n_bad++; $display("FAIL en_01 got %h want 01", va); end
        step(2);
        en = 1'b0; prev = da; trans = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (da !== prev) trans++;
            prev = da;
        end
        n_cmp++; if (va !== 8'h01) begin n_bad++; $display("FAIL en_frozen got %h want 01", va); end
        n_cmp++; if (trans !== 5) begin n_bad++; $display("FAIL en_scan got %0d want 5", trans); end
        en = 1'b1;
        step(1);
        n_cmp++; if (va !== 8'h01) begin n_bad++; $display("FAIL en_resume1 got %h want 01", va); end
        step(1);
        n_cmp++; if (va !== 8'h02) begin n_bad++; $display("FAIL en_resume2 got %h want 02", va); end
    endtask

    task automatic test_display();
        int idx;
        logic [3:0] edig;
        logic [7:0] ec, ed;
        do_reset(); en = 1'b0; up = 1'b1;
        load_pulse(16'h0007);
        for (int k = 2; k <= 17; k++) begin
            step(1);
            idx  = ((k - 1) / 2) % 4;
            edig = ~(4'b0001 << idx);
            ec   = (idx == 0) ? 8'hF8 : 8'hFF;
            ed   = (idx == 0) ? 8'hF8 : 8'hC0;
            n_cmp++; if (dc !== edig) begin n_bad++; $display("FAIL disp_dig k=%0d got %h want %h", k, dc, edig); end
            n_cmp++; if (sc !== ec) begin n_bad++; $display("FAIL disp_seg_lz k=%0d got %h want %h", k, sc, ec); end
            n_cmp++; if (dd !== edig) begin n_bad++; $display("FAIL disp_dig_nolz k=%0d got %h want %h", k, dd, edig); end
            n_cmp++; if (sd !== ed) begin n_bad++; $display("FAIL disp_seg_nolz k=%0d got %h want %h", k, sd, ed); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(); en = 1'b1; up = 1'b1;
        load_pulse(16'h0037);
        step(2);
        n_cmp++; if (va !== 8'h37) begin n_bad++; $display("FAIL rm_pre got %h want 37", va); end
        rst = 1'b1; load = 1'b1; lv = 16'h0012;
        step(1);
        rst = 1'b0; load = 1'b0;
        n_cmp++; if (va !== 8'h00) begin n_bad++; $display("FAIL rm_value got %h want 00", va); end
        n_cmp++; if (wa !== 1'b0) begin n_bad++; $display("FAIL rm_wrap got %b want 0", wa); end
        n_cmp++; if (sc !== 8'hFF) begin n_bad++; $display("FAIL rm_seg got %h want FF", sc); end
        n_cmp++; if (dc !== 4'hF) begin n_bad++; $display("FAIL rm_dig got %h want F", dc); end
        n_cmp++; if (vc !== 16'h0000) begin n_bad++; $display("FAIL rm_value4 got %h want 0000", vc); end
        step(1);
        n_cmp++; if (dc !== 4'hE) begin n_bad++; $display("FAIL rm_onehot got %h want E", dc); end
        n_cmp++; if (va !== 8'h00) begin n_bad++; $display("FAIL rm_hold got %h want 00", va); end
        step(3);
        n_cmp++; if (va !== 8'h01) begin n_bad++; $display("FAIL rm_resume got %h want 01", va); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = '0;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_enable();
        test_display();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
